// File: rtl/vrased_reset_ctrl_pkg.sv
// Shared constants and types for the VRASED reset controller.
package vrased_reset_ctrl_pkg;

    localparam int unsigned ViolWidth = 6;

    // Bit positions of the per-monitor violation pulses
    localparam int unsigned ViolXStack    = 0;
    localparam int unsigned ViolAc        = 1;
    localparam int unsigned ViolAtomicity = 2;
    localparam int unsigned ViolDmaAc     = 3;
    localparam int unsigned ViolDmaDetect = 4;
    localparam int unsigned ViolDmaXStack = 5;

    localparam logic [15:0] DefaultResetHandler   = 16'h0000;
    localparam int unsigned DefaultHoldCycles     = 8;
    localparam int unsigned DefaultHandlerTimeout = 16;

    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StHold        = 2'd1,
        StWaitHandler = 2'd2
    } state_e;

endpackage

// File: rtl/vrased_reset_ctrl_if.sv
// Monitor-side inputs and CPU-side outputs of the reset controller.
interface vrased_reset_ctrl_if;
    import vrased_reset_ctrl_pkg::*;

    logic [ViolWidth-1:0] violation;
    logic [15:0]          pc;
    logic                 cause_clr;
    logic                 cpu_reset;
    logic [ViolWidth-1:0] first_cause;
    logic [ViolWidth-1:0] cause_log;
    logic [7:0]           viol_count;
    logic                 busy;

    modport master (
        output violation, pc, cause_clr,
        input  cpu_reset, first_cause, cause_log, viol_count, busy
    );

    modport slave (
        input  violation, pc, cause_clr,
        output cpu_reset, first_cause, cause_log, viol_count, busy
    );

endinterface

// File: rtl/vrased_sat_counter.sv
// Up-counter with enable that sticks at all-ones instead of wrapping.
module vrased_sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q;

    // Count enabled cycles, holding once every bit is set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (en && (count_q != {Width{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vrased_reset_ctrl.sv
// Holds the CPU in reset after any monitor violation, then waits for the PC
// to reach the reset handler, re-entering the hold on a new violation or timeout.
module vrased_reset_ctrl
    import vrased_reset_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_HANDLER   = DefaultResetHandler,
    parameter int unsigned HOLD_CYCLES     = DefaultHoldCycles,
    parameter int unsigned HANDLER_TIMEOUT = DefaultHandlerTimeout
) (
    input logic               clk,
    input logic               reset,
    vrased_reset_ctrl_if.slave bus
);

    // Counters run from N-1 down to 0, giving exactly N cycles per phase
    localparam logic [7:0] HoldLoad    = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] TimeoutLoad = 8'(HANDLER_TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [7:0]           hold_cnt_q, hold_cnt_d;
    logic [7:0]           tmo_cnt_q, tmo_cnt_d;
    logic                 cpu_reset_q, cpu_reset_d;
    logic [ViolWidth-1:0] first_cause_q, first_cause_d;
    logic [ViolWidth-1:0] cause_log_q, cause_log_d;
    logic [7:0]           viol_count;
    logic                 viol_any;
    logic                 busy;

    assign viol_any = |bus.violation;

    // State register; cpu_reset is registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            hold_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            cpu_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    // Next-state and down-counter logic
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (viol_any) begin
                    state_d    = StHold;
                    hold_cnt_d = HoldLoad;
                end
            end
            StHold: begin
                // A fresh violation stretches the hold
                if (viol_any) begin
                    hold_cnt_d = HoldLoad;
                end else if (hold_cnt_q == 8'd0) begin
                    state_d   = StWaitHandler;
                    tmo_cnt_d = TimeoutLoad;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            StWaitHandler: begin
                // Violation outranks a same-cycle handler match
                if (viol_any) begin
                    state_d    = StHold;
                    hold_cnt_d = HoldLoad;
                end else if (bus.pc == RESET_HANDLER) begin
                    state_d = StIdle;
                end else if (tmo_cnt_q == 8'd0) begin
                    state_d    = StHold;
                    hold_cnt_d = HoldLoad;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode
    always_comb begin
        cpu_reset_d = (state_d == StHold);
        busy        = (state_q != StIdle);
    end

    // Cause tracking; a clear takes effect before same-cycle violation bits merge in
    always_comb begin
        cause_log_d   = (bus.cause_clr ? '0 : cause_log_q) | bus.violation;
        first_cause_d = first_cause_q;
        if (bus.cause_clr) begin
            first_cause_d = bus.violation;
        end else if ((state_q == StIdle) && viol_any) begin
            first_cause_d = bus.violation;
        end
    end

    // Cause registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_cause_q <= '0;
            cause_log_q   <= '0;
        end else begin
            first_cause_q <= first_cause_d;
            cause_log_q   <= cause_log_d;
        end
    end

    vrased_sat_counter #(
        .Width (8)
    ) u_viol_count (
        .clk   (clk),
        .reset (reset),
        .en    (viol_any),
        .count (viol_count)
    );

    assign bus.cpu_reset   = cpu_reset_q;
    assign bus.busy        = busy;
    assign bus.first_cause = first_cause_q;
    assign bus.cause_log   = cause_log_q;
    assign bus.viol_count  = viol_count;

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Scoreboard bench: each test pushes the expected next-cycle outputs as it drives
// a cycle, and pops/compares them one clock later.
module tb_vrased_reset_ctrl;

    typedef struct packed {
        logic cpu_reset;
        logic busy;
    } exp_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    exp_t exp_q[$];

    vrased_reset_ctrl_if bus();

    vrased_reset_ctrl #(
        .RESET_HANDLER   (16'h0000),
        .HOLD_CYCLES     (8),
        .HANDLER_TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset         = 1'b1;
        bus.violation = '0;
        bus.cause_clr = 1'b0;
        bus.pc        = 16'hA000;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.violation = 6'b111111;
        bus.cause_clr = 1'b0;
        bus.pc        = 16'hA000;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.cpu_reset !== 1'b0) begin errors++; $display("FAIL reset cpu_reset got %b exp 0", bus.cpu_reset); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b exp 0", bus.busy); end
        checks++; if (bus.first_cause !== 6'b0) begin errors++; $display("FAIL reset first_cause got %b exp 0", bus.first_cause); end
        checks++; if (bus.cause_log !== 6'b0) begin errors++; $display("FAIL reset cause_log got %b exp 0", bus.cause_log); end
        checks++; if (bus.viol_count !== 8'h00) begin errors++; $display("FAIL reset viol_count got %h exp 00", bus.viol_count); end
        bus.violation = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Single-cycle violation, handler reached at cycle 12
    task automatic test_single();
        exp_t e;
        do_reset();
        for (int c = 0; c <= 15; c++) begin
            @(posedge clk); #1;
            if (c > 0) begin
                e = exp_q.pop_front();
                checks++; if (bus.cpu_reset !== e.cpu_reset) begin errors++; $display("FAIL single cpu_reset c=%0d got %b exp %b", c, bus.cpu_reset, e.cpu_reset); end
                checks++; if (bus.busy !== e.busy) begin errors++; $display("FAIL single busy c=%0d got %b exp %b", c, bus.busy, e.busy); end
            end
            bus.violation = (c == 0) ? 6'b000100 : 6'b000000;
            bus.pc        = (c == 12) ? 16'h0000 : 16'hA000;
            e.cpu_reset   = (c + 1 >= 1) && (c + 1 <= 8);
            e.busy        = (c + 1 <= 12);
            exp_q.push_back(e);
        end
        exp_q.delete();
        checks++; if (bus.first_cause !== 6'b000100) begin errors++; $display("FAIL single first_cause got %b exp 000100", bus.first_cause); end
        checks++; if (bus.cause_log !== 6'b000100) begin errors++; $display("FAIL single cause_log got %b exp 000100", bus.cause_log); end
        checks++; if (bus.viol_count !== 8'd1) begin errors++; $display("FAIL single viol_count got %0d exp 1", bus.viol_count); end
        // Clear leaves the count alone
        bus.cause_clr = 1'b1;
        @(posedge clk); #1;
        bus.cause_clr = 1'b0;
        checks++; if (bus.cause_log !== 6'b0) begin errors++; $display("FAIL clr cause_log got %b exp 0", bus.cause_log); end
        checks++; if (bus.first_cause !== 6'b0) begin errors++; $display("FAIL clr first_cause got %b exp 0", bus.first_cause); end
        checks++; if (bus.viol_count !== 8'd1) begin errors++; $display("FAIL clr viol_count got %0d exp 1", bus.viol_count); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clr busy got %b exp 0", bus.busy); end
    endtask

    // Second violation during hold stretches it
    task automatic test_stretch();
        exp_t e;
        do_reset();
        for (int c = 0; c <= 18; c++) begin
            @(posedge clk); #1;
            if (c > 0) begin
                e = exp_q.pop_front();
                checks++; if (bus.cpu_reset !== e.cpu_reset) begin errors++; $display("FAIL stretch cpu_reset c=%0d got %b exp %b", c, bus.cpu_reset, e.cpu_reset); end
                checks++; if (bus.busy !== e.busy) begin errors++; $display("FAIL stretch busy c=%0d got %b exp %b", c, bus.busy, e.busy); end
            end
            bus.violation = (c == 0) ? 6'b000001 : (c == 4) ? 6'b100000 : 6'b000000;
            bus.pc        = (c == 16) ? 16'h0000 : 16'hA000;
            e.cpu_reset   = (c + 1 >= 1) && (c + 1 <= 12);
            e.busy        = (c + 1 <= 16);
            exp_q.push_back(e);
        end
        exp_q.delete();
        checks++; if (bus.first_cause !== 6'b000001) begin errors++; $display("FAIL stretch first_cause got %b exp 000001", bus.first_cause); end
        checks++; if (bus.cause_log !== 6'b100001) begin errors++; $display("FAIL stretch cause_log got %b exp 100001", bus.cause_log); end
        checks++; if (bus.viol_count !== 8'd2) begin errors++; $display("FAIL stretch viol_count got %0d exp 2", bus.viol_count); end
    endtask

    // Handler never reached: timeout re-enters hold, then handler exits at cycle 34
    task automatic test_timeout();
        exp_t e;
        do_reset();
        for (int c = 0; c <= 36; c++) begin
            @(posedge clk); #1;
            if (c > 0) begin
                e = exp_q.pop_front();
                checks++; if (bus.cpu_reset !== e.cpu_reset) begin errors++; $display("FAIL timeout cpu_reset c=%0d got %b exp %b", c, bus.cpu_reset, e.cpu_reset); end
                checks++; if (bus.busy !== e.busy) begin errors++; $display("FAIL timeout busy c=%0d got %b exp %b", c, bus.busy, e.busy); end
            end
            bus.violation = (c == 0) ? 6'b000010 : 6'b000000;
            bus.pc        = (c == 34) ? 16'h0000 : 16'hA000;
            e.cpu_reset   = ((c + 1 >= 1) && (c + 1 <= 8)) || ((c + 1 >= 25) && (c + 1 <= 32));
            e.busy        = (c + 1 <= 34);
            exp_q.push_back(e);
        end
        exp_q.delete();
        checks++; if (bus.viol_count !== 8'd1) begin errors++; $display("FAIL timeout viol_count got %0d exp 1", bus.viol_count); end
    endtask

    // Violation and handler match in the same wait cycle: violation wins
    task automatic test_wait_priority();
        exp_t e;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c > 0) begin
                e = exp_q.pop_front();
                checks++; if (bus.cpu_reset !== e.cpu_reset) begin errors++; $display("FAIL prio cpu_reset c=%0d got %b exp %b", c, bus.cpu_reset, e.cpu_reset); end
            end
            bus.violation = (c == 0) ? 6'b001000 : (c == 10) ? 6'b000010 : 6'b000000;
            bus.pc        = (c == 10) ? 16'h0000 : 16'hA000;
            e.cpu_reset   = ((c + 1 >= 1) && (c + 1 <= 8)) || ((c + 1 >= 11) && (c + 1 <= 18));
            e.busy        = 1'b1;
            exp_q.push_back(e);
        end
        exp_q.delete();
        checks++; if (bus.first_cause !== 6'b001000) begin errors++; $display("FAIL prio first_cause got %b exp 001000", bus.first_cause); end
    endtask

    // 301 violation cycles saturate the count; clear with violation loads new bits
    task automatic test_saturate();
        exp_t e;
        do_reset();
        for (int c = 0; c <= 310; c++) begin
            @(posedge clk); #1;
            if (c > 0) begin
                e = exp_q.pop_front();
                checks++; if (bus.cpu_reset !== e.cpu_reset) begin errors++; $display("FAIL sat cpu_reset c=%0d got %b exp %b", c, bus.cpu_reset, e.cpu_reset); end
            end
            if (c == 301) begin
                checks++; if (bus.viol_count !== 8'hFF) begin errors++; $display("FAIL sat viol_count got %h exp ff", bus.viol_count); end
                checks++; if (bus.cause_log !== 6'b010000) begin errors++; $display("FAIL sat cause_log got %b exp 010000", bus.cause_log); end
                checks++; if (bus.first_cause !== 6'b010000) begin errors++; $display("FAIL sat first_cause got %b exp 010000", bus.first_cause); end
            end
            bus.violation = (c < 300) ? 6'b000001 : (c == 300) ? 6'b010000 : 6'b000000;
            bus.cause_clr = (c == 300);
            e.cpu_reset   = (c + 1 >= 1) && (c + 1 <= 308);
            e.busy        = 1'b1;
            exp_q.push_back(e);
        end
        exp_q.delete();
        checks++; if (bus.viol_count !== 8'hFF) begin errors++; $display("FAIL sat hold viol_count got %h exp ff", bus.viol_count); end
    endtask

    // Asynchronous reset in the middle of a hold
    task automatic test_reset_mid_hold();
        do_reset();
        @(posedge clk); #1;
        bus.violation = 6'b000100;
        @(posedge clk); #1;
        bus.violation = 6'b000000;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.cpu_reset !== 1'b1) begin errors++; $display("FAIL midhold pre cpu_reset got %b exp 1", bus.cpu_reset); end
        #2;
        reset         = 1'b1;
        bus.violation = 6'b111111;
        #1;
        checks++; if (bus.cpu_reset !== 1'b0) begin errors++; $display("FAIL midhold cpu_reset got %b exp 0", bus.cpu_reset); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midhold busy got %b exp 0", bus.busy); end
        checks++; if (bus.cause_log !== 6'b0) begin errors++; $display("FAIL midhold cause_log got %b exp 0", bus.cause_log); end
        checks++; if (bus.viol_count !== 8'd0) begin errors++; $display("FAIL midhold viol_count got %0d exp 0", bus.viol_count); end
        checks++; if (bus.first_cause !== 6'b0) begin errors++; $display("FAIL midhold first_cause got %b exp 0", bus.first_cause); end
        @(posedge clk); #1;
        checks++; if (bus.viol_count !== 8'd0) begin errors++; $display("FAIL midhold ignored viol_count got %0d exp 0", bus.viol_count); end
        bus.violation = 6'b000000;
        @(negedge clk);
        reset = 1'b0;
        // First edge after release evaluates normally
        bus.violation = 6'b001000;
        @(posedge clk); #1;
        bus.violation = 6'b000000;
        checks++; if (bus.cpu_reset !== 1'b1) begin errors++; $display("FAIL postrst cpu_reset got %b exp 1", bus.cpu_reset); end
        checks++; if (bus.first_cause !== 6'b001000) begin errors++; $display("FAIL postrst first_cause got %b exp 001000", bus.first_cause); end
        checks++; if (bus.viol_count !== 8'd1) begin errors++; $display("FAIL postrst viol_count got %0d exp 1", bus.viol_count); end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        bus.violation = '0;
        bus.pc        = 16'hA000;
        bus.cause_clr = 1'b0;
        test_reset();
        test_single();
        test_stretch();
        test_timeout();
        test_wait_priority();
        test_saturate();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
